// File: rtl/bcd_display_scanner_pkg.sv
// rtl/bcd_display_scanner_pkg.sv - shared constants and helpers for the BCD display scanner
package bcd_display_scanner_pkg;

    localparam int BCD_W = 4;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg.sv
// rtl/bcd_display_scanner_bcd_to_seg.sv - combinational BCD to 7-segment decoder with dash for codes 10-15
module bcd_to_seg
    import bcd_display_scanner_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - snapshot a packed BCD value and scan it onto a multiplexed 7-segment display
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int LZB      = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_n,
    input  logic                      blank_n,
    input  logic [BCD_W*DIGITS-1:0]   digits_in,
    output logic [6:0]                seg_out,
    output logic [DIGITS-1:0]         digit_sel,
    output logic                      frame_done
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int PS_W  = idx_width(PRESCALE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(PRESCALE - 1);

    logic [BCD_W*DIGITS-1:0] snapshot;
    logic [PS_W-1:0]         prescaler;
    logic [IDX_W-1:0]        index;

    logic [BCD_W-1:0]        cur_digit;
    logic [DIGITS-1:0]       sel_next;
    logic                    upper_zero;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_next;
    logic                    ps_wrap;
    logic                    idx_wrap;

    // Select the current digit and check whether it and every more-significant digit are zero.
    always_comb begin
        cur_digit  = '0;
        sel_next   = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (index == IDX_W'(i)) begin
                cur_digit   = snapshot[BCD_W*i +: BCD_W];
                sel_next[i] = 1'b1;
            end
            if ((IDX_W'(i) >= index) && (snapshot[BCD_W*i +: BCD_W] != '0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Digit 0 always shows so a zero value still displays "0".
    always_comb begin
        seg_next = dec_seg;
        if ((LZB != 0) && (index != '0) && upper_zero) begin
            seg_next = SEG_OFF;
        end
    end

    assign ps_wrap  = (prescaler == LAST_PS);
    assign idx_wrap = ps_wrap && (index == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            snapshot   <= '0;
            prescaler  <= '0;
            index      <= '0;
            seg_out    <= SEG_OFF;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (!load_n) begin
                snapshot <= digits_in;
            end

            if (ps_wrap) begin
                prescaler <= '0;
                index     <= (index == LAST_IDX) ? '0 : index + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            frame_done <= idx_wrap;

            // Blanking only gates the pins; scanning keeps running underneath.
            if (!blank_n) begin
                seg_out   <= SEG_OFF;
                digit_sel <= '0;
            end else begin
                seg_out   <= seg_next;
                digit_sel <= sel_next;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - table-driven self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

    logic        clock;
    logic        reset;
    logic        load_n;
    logic        blank_n;
    logic [15:0] digits_in;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic [3:0]  sel_a, sel_b, sel_c;
    logic        fd_a, fd_b, fd_c;

    bcd_display_scanner #(.DIGITS(4), .PRESCALE(3), .LZB(1)) dut_a (
        .clock(clock), .reset(reset), .load_n(load_n), .blank_n(blank_n),
        .digits_in(digits_in), .seg_out(seg_a), .digit_sel(sel_a), .frame_done(fd_a)
    );

    bcd_display_scanner #(.DIGITS(4), .PRESCALE(3), .LZB(0)) dut_b (
        .clock(clock), .reset(reset), .load_n(load_n), .blank_n(blank_n),
        .digits_in(digits_in), .seg_out(seg_b), .digit_sel(sel_b), .frame_done(fd_b)
    );

    bcd_display_scanner #(.DIGITS(4), .PRESCALE(1), .LZB(1)) dut_c (
        .clock(clock), .reset(reset), .load_n(load_n), .blank_n(blank_n),
        .digits_in(digits_in), .seg_out(seg_c), .digit_sel(sel_c), .frame_done(fd_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]     value;
        logic [3:0][6:0] s1;   // expected segments per digit with blanking, {d3,d2,d1,d0}
        logic [3:0][6:0] s0;   // expected segments per digit without blanking
    } vec_t;

    localparam int NROWS    = 8;
    localparam int ZERO_ROW = 2;
    vec_t tbl [NROWS];

    int checks;
    int passes;
    int n;          // edges since reset release
    int cur_row;    // row held in the snapshot
    int disp_row;   // row the outputs were computed from at the last edge
    int pend_row;
    bit rst_s;
    bit blank_s;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
    endtask

    task automatic check_dut(input string name, input int prescale, input bit lzb,
                             input logic [6:0] seg, input logic [3:0] sel, input logic fd);
        int d;
        logic [6:0] e_seg;
        logic [3:0] e_sel;
        logic       e_fd;
        if (rst_s) begin
            e_seg = 7'b0;
            e_sel = 4'b0;
            e_fd  = 1'b0;
        end else begin
            d     = ((n - 1) / prescale) % 4;
            e_fd  = ((n % (4 * prescale)) == 0);
            e_sel = blank_s ? 4'b0 : 4'(1 << d);
            e_seg = blank_s ? 7'b0 : (lzb ? tbl[disp_row].s1[d] : tbl[disp_row].s0[d]);
        end
        cmp({name, ".seg_out"}, int'(seg), int'(e_seg));
        cmp({name, ".digit_sel"}, int'(sel), int'(e_sel));
        cmp({name, ".frame_done"}, int'(fd), int'(e_fd));
    endtask

    task automatic step();
        @(posedge clock);
        rst_s    = reset;
        blank_s  = !blank_n;
        disp_row = cur_row;
        if (reset) begin
            n       = 0;
            cur_row = ZERO_ROW;
        end else begin
            n++;
            if (!load_n) cur_row = pend_row;
        end
        #1;
        check_dut("a", 3, 1'b1, seg_a, sel_a, fd_a);
        check_dut("b", 3, 1'b0, seg_b, sel_b, fd_b);
        check_dut("c", 1, 1'b1, seg_c, sel_c, fd_c);
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    // Single-edge load pulse; outputs start reflecting the row from the following edge.
    task automatic load_row(input int r);
        digits_in = tbl[r].value;
        pend_row  = r;
        load_n    = 1'b0;
        step();
        load_n    = 1'b1;
        digits_in = 16'hFFFF;
    endtask

    initial begin
        tbl[0] = '{16'h1234, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110},
                             {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}};
        tbl[1] = '{16'h0050, {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111},
                             {7'b0111111, 7'b0111111, 7'b1101101, 7'b0111111}};
        tbl[2] = '{16'h0000, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111},
                             {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        tbl[3] = '{16'h00A0, {7'b0000000, 7'b0000000, 7'b1000000, 7'b0111111},
                             {7'b0111111, 7'b0111111, 7'b1000000, 7'b0111111}};
        tbl[4] = '{16'hF000, {7'b1000000, 7'b0111111, 7'b0111111, 7'b0111111},
                             {7'b1000000, 7'b0111111, 7'b0111111, 7'b0111111}};
        tbl[5] = '{16'h9999, {7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111},
                             {7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111}};
        tbl[6] = '{16'h8076, {7'b1111111, 7'b0111111, 7'b0000111, 7'b1111101},
                             {7'b1111111, 7'b0111111, 7'b0000111, 7'b1111101}};
        tbl[7] = '{16'h0109, {7'b0000000, 7'b0000110, 7'b0111111, 7'b1101111},
                             {7'b0111111, 7'b0000110, 7'b0111111, 7'b1101111}};

        checks    = 0;
        passes    = 0;
        n         = 0;
        cur_row   = ZERO_ROW;
        disp_row  = ZERO_ROW;
        pend_row  = ZERO_ROW;
        reset     = 1'b1;
        load_n    = 1'b1;
        blank_n   = 1'b1;
        digits_in = 16'h0000;

        #1;
        run(2);
        reset = 1'b0;
        run(5);

        for (int r = 0; r < NROWS; r++) begin
            load_row(r);
            run(13);
        end

        // Reset mid-scan, with a load on the same edge that must lose to reset.
        load_row(0);
        run(4);
        reset     = 1'b1;
        digits_in = tbl[5].value;
        pend_row  = 5;
        load_n    = 1'b0;
        step();
        load_n    = 1'b1;
        step();
        reset     = 1'b0;
        run(13);

        // Load while blanked still captures; scanning and frame_done continue.
        blank_n = 1'b0;
        load_row(5);
        run(14);
        blank_n = 1'b1;
        run(13);

        // Loads at assorted scan phases must not disturb prescaler or index.
        for (int r = 0; r < 3; r++) begin
            run(r + 1);
            load_row(6 + (r % 2));
            run(5);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
